// File: rtl/xgmii_tx_scheduler.sv
// 64-bit MAC to 32-bit XGMII TX scheduler: splits words lower-half first, inserts
// full-width idles at 64-bit boundaries, honours PCS pause. Stats via XGMII_TX_SCHED_STATS_EN.
module xgmii_tx_scheduler #(
    parameter logic [7:0] IDLE_CHAR = 8'h07
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [63:0] i_mac_txd,
    input  logic [7:0]  i_mac_txc,
    input  logic        i_mac_valid,
    output logic        o_mac_ready,
    output logic [31:0] o_xgmii_txd,
    output logic [3:0]  o_xgmii_txc,
    output logic        o_xgmii_valid,
    input  logic        i_xgmii_pause
`ifdef XGMII_TX_SCHED_STATS_EN
    ,
    output logic [15:0] o_idle_words,
    output logic [15:0] o_pause_cycles
`endif
);

    localparam int unsigned HALF_W = 32;
    localparam int unsigned CTL_W  = 4;
    localparam int unsigned CNT_W  = 16;

    localparam logic [HALF_W-1:0] IDLE_TXD = {4{IDLE_CHAR}};
    localparam logic [CTL_W-1:0]  IDLE_TXC = 4'hF;

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_e;

    phase_e             phase_q, phase_d;
    logic [HALF_W-1:0]  txd_q, txd_d;
    logic [CTL_W-1:0]   txc_q, txc_d;
    logic               valid_q, valid_d;
    logic [HALF_W-1:0]  hold_txd_q, hold_txd_d;
    logic [CTL_W-1:0]   hold_txc_q, hold_txc_d;
    logic               idle_ins;

    // Ready is combinational from pause so a paused LO cycle never handshakes.
    assign o_mac_ready = (phase_q == PH_LO) && !i_xgmii_pause && !i_reset;

    always_comb begin
        phase_d    = phase_q;
        txd_d      = txd_q;
        txc_d      = txc_q;
        valid_d    = 1'b0;
        hold_txd_d = hold_txd_q;
        hold_txc_d = hold_txc_q;
        idle_ins   = 1'b0;
        if (!i_xgmii_pause) begin
            valid_d = 1'b1;
            if (phase_q == PH_LO) begin
                phase_d = PH_HI;
                if (i_mac_valid) begin
                    txd_d      = i_mac_txd[31:0];
                    txc_d      = i_mac_txc[3:0];
                    hold_txd_d = i_mac_txd[63:32];
                    hold_txc_d = i_mac_txc[7:4];
                end else begin
                    idle_ins   = 1'b1;
                    txd_d      = IDLE_TXD;
                    txc_d      = IDLE_TXC;
                    hold_txd_d = IDLE_TXD;
                    hold_txc_d = IDLE_TXC;
                end
            end else begin
                phase_d = PH_LO;
                txd_d   = hold_txd_q;
                txc_d   = hold_txc_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase_q    <= PH_LO;
            txd_q      <= IDLE_TXD;
            txc_q      <= IDLE_TXC;
            valid_q    <= 1'b0;
            hold_txd_q <= IDLE_TXD;
            hold_txc_q <= IDLE_TXC;
        end else begin
            phase_q    <= phase_d;
            txd_q      <= txd_d;
            txc_q      <= txc_d;
            valid_q    <= valid_d;
            hold_txd_q <= hold_txd_d;
            hold_txc_q <= hold_txc_d;
        end
    end

    assign o_xgmii_txd   = txd_q;
    assign o_xgmii_txc   = txc_q;
    assign o_xgmii_valid = valid_q;

`ifdef XGMII_TX_SCHED_STATS_EN
    logic [CNT_W-1:0] idle_words_q, idle_words_d;
    logic [CNT_W-1:0] pause_cycles_q, pause_cycles_d;

    // Saturating event counters.
    always_comb begin
        idle_words_d   = idle_words_q;
        pause_cycles_d = pause_cycles_q;
        if (idle_ins && (idle_words_q != {CNT_W{1'b1}})) begin
            idle_words_d = idle_words_q + CNT_W'(1);
        end
        if (i_xgmii_pause && (pause_cycles_q != {CNT_W{1'b1}})) begin
            pause_cycles_d = pause_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            idle_words_q   <= '0;
            pause_cycles_q <= '0;
        end else begin
            idle_words_q   <= idle_words_d;
            pause_cycles_q <= pause_cycles_d;
        end
    end

    assign o_idle_words   = idle_words_q;
    assign o_pause_cycles = pause_cycles_q;
`endif

endmodule
